// File: rtl/combiner_pkg.sv
// ---------------------------------------------------------------------------
// combiner_pkg
// Shared constants and helpers for the two-stream join (combiner).
//   BURST_ON      : value of the BURST parameter that selects full throughput
//   fireCondition : decides when the two held beats move into the output stage
// ---------------------------------------------------------------------------
package combiner_pkg;

   localparam string BURST_ON = "yes";

   // A join fires only when both slots hold a beat and the output register is
   // either empty or being drained on this same edge.
   function automatic logic fireCondition(input logic full0,
                                          input logic full1,
                                          input logic outValid,
                                          input logic outReady);
      return full0 & full1 & (~outValid | outReady);
   endfunction

endpackage

// File: rtl/combiner_slot.sv
// ---------------------------------------------------------------------------
// combiner_slot
// One-entry holding register: a full flag plus a data word.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   set          : capture dIn and mark the slot full
//   clear        : mark the slot empty (data keeps its last value)
//   dIn          : data to capture on set
//   full         : slot currently holds a beat
//   data         : held beat
// ---------------------------------------------------------------------------
module combiner_slot #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             set,
   input  logic             clear,
   input  logic [WIDTH-1:0] dIn,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   // Set has priority over clear so that a slot emptied and refilled on the
   // same edge stays full with the fresh beat. Data only moves on set, which
   // keeps it stable while a downstream consumer is stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full <= 1'b0;
         data <= '0;
      end else begin
         if (set) begin
            full <= 1'b1;
            data <= dIn;
         end else if (clear) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/combiner.sv
// ---------------------------------------------------------------------------
// combiner
// Joins one beat from each of two valid/ready streams into a single output
// beat {data0, data1}, stream 0 in the upper bits. Each input has a one-entry
// slot so beats may arrive in different cycles; a registered output stage
// follows the slots.
// Parameters:
//   WIDTH0, WIDTH1 : data widths of stream 0 and stream 1
//   BURST          : "yes" = one beat per cycle (ready depends on iReady_BM)
//                    otherwise = registered readies, one beat per two cycles
// Ports:
//   iCLK, iRST                          : clock, async active-high reset
//   iValid_AM0, oReady_AM0, iData_AM0   : input stream 0
//   iValid_AM1, oReady_AM1, iData_AM1   : input stream 1
//   oValid_BM, iReady_BM, oData_BM      : joined output stream
// ---------------------------------------------------------------------------
module combiner
   import combiner_pkg::*;
#(
   parameter int    WIDTH0 = 4,
   parameter int    WIDTH1 = 4,
   parameter string BURST  = "yes"
) (
   input  logic                     iCLK,
   input  logic                     iRST,
   input  logic                     iValid_AM0,
   output logic                     oReady_AM0,
   input  logic [WIDTH0-1:0]        iData_AM0,
   input  logic                     iValid_AM1,
   output logic                     oReady_AM1,
   input  logic [WIDTH1-1:0]        iData_AM1,
   output logic                     oValid_BM,
   input  logic                     iReady_BM,
   output logic [WIDTH0+WIDTH1-1:0] oData_BM
);

   logic              full0;
   logic              full1;
   logic [WIDTH0-1:0] data0;
   logic [WIDTH1-1:0] data1;
   logic              accept0;
   logic              accept1;
   logic              fire;
   logic              drain;

   // Handshake decode: a beat enters a slot on valid & ready, the pair moves
   // to the output register on fire, and the output empties when the consumer
   // takes it without a replacement arriving on the same edge.
   assign accept0 = iValid_AM0 & oReady_AM0;
   assign accept1 = iValid_AM1 & oReady_AM1;
   assign fire    = fireCondition(full0, full1, oValid_BM, iReady_BM);
   assign drain   = oValid_BM & iReady_BM;

   // Input slot for stream 0; cleared by fire unless refilled on that edge.
   combiner_slot #(.WIDTH(WIDTH0)) slot0 (
      .clock (iCLK),
      .reset (iRST),
      .set   (accept0),
      .clear (fire),
      .dIn   (iData_AM0),
      .full  (full0),
      .data  (data0)
   );

   // Input slot for stream 1; same behaviour as slot 0.
   combiner_slot #(.WIDTH(WIDTH1)) slot1 (
      .clock (iCLK),
      .reset (iRST),
      .set   (accept1),
      .clear (fire),
      .dIn   (iData_AM1),
      .full  (full1),
      .data  (data1)
   );

   // Output register: loads the joined pair on fire, and a fire on the same
   // edge as a drain wins so back-to-back beats keep oValid_BM high.
   combiner_slot #(.WIDTH(WIDTH0 + WIDTH1)) outStage (
      .clock (iCLK),
      .reset (iRST),
      .set   (fire),
      .clear (drain),
      .dIn   ({data0, data1}),
      .full  (oValid_BM),
      .data  (oData_BM)
   );

   // Ready generation. In burst mode a full slot may accept again on the edge
   // it is emptied by fire, which gives full throughput at the cost of a
   // combinational path from iReady_BM. Otherwise ready is the inverted flop,
   // so a slot only reopens the cycle after it empties.
   generate
      if (BURST == BURST_ON) begin : gBurst
         assign oReady_AM0 = ~full0 | fire;
         assign oReady_AM1 = ~full1 | fire;
      end else begin : gNoBurst
         assign oReady_AM0 = ~full0;
         assign oReady_AM1 = ~full1;
      end
   endgenerate

endmodule

// File: tb/tb_combiner.sv
// ---------------------------------------------------------------------------
// tb_combiner
// Drives one combiner built with BURST="yes" (index 0) and one with
// BURST="no" (index 1). Expected joined beats are queued when stimulus is
// driven and popped by a monitor whenever a DUT hands over an output beat.
// ---------------------------------------------------------------------------
module tb_combiner;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      valid0;
   logic [1:0]      valid1;
   logic [1:0]      ready0;
   logic [1:0]      ready1;
   logic [1:0]      outValid;
   logic [1:0]      outReady;
   logic [1:0][3:0] data0;
   logic [1:0][3:0] data1;
   logic [1:0][7:0] outData;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycle       = 0;
   int outCount[2];
   int firstOut[2];
   int lastOut[2];

   logic [7:0] expQ0[$];
   logic [7:0] expQ1[$];

   // Free-running clock and a cycle counter used for throughput spans.
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   combiner #(.WIDTH0(4), .WIDTH1(4), .BURST("yes")) dutBurst (
      .iCLK       (clk),
      .iRST       (reset),
      .iValid_AM0 (valid0[0]),
      .oReady_AM0 (ready0[0]),
      .iData_AM0  (data0[0]),
      .iValid_AM1 (valid1[0]),
      .oReady_AM1 (ready1[0]),
      .iData_AM1  (data1[0]),
      .oValid_BM  (outValid[0]),
      .iReady_BM  (outReady[0]),
      .oData_BM   (outData[0])
   );

   combiner #(.WIDTH0(4), .WIDTH1(4), .BURST("no")) dutNoBurst (
      .iCLK       (clk),
      .iRST       (reset),
      .iValid_AM0 (valid0[1]),
      .oReady_AM0 (ready0[1]),
      .iData_AM0  (data0[1]),
      .iValid_AM1 (valid1[1]),
      .oReady_AM1 (ready1[1]),
      .iData_AM1  (data1[1]),
      .oValid_BM  (outValid[1]),
      .iReady_BM  (outReady[1]),
      .oData_BM   (outData[1])
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pushExpected(input int d, input logic [7:0] value);
      if (d == 0) expQ0.push_back(value);
      else        expQ1.push_back(value);
   endtask

   // Output monitor for one DUT: each accepted output beat must match the
   // oldest queued expectation; a beat with nothing queued is an error.
   task automatic watchOutput(input int d);
      logic [7:0] expected;
      if (outValid[d] && outReady[d]) begin
         if ((d == 0 && expQ0.size() == 0) || (d == 1 && expQ1.size() == 0)) begin
            checkOutput(d == 0 ? "spuriousYes" : "spuriousNo", 32'd1, 32'd0);
         end else begin
            if (d == 0) expected = expQ0.pop_front();
            else        expected = expQ1.pop_front();
            checkOutput(d == 0 ? "beatYes" : "beatNo", {24'd0, outData[d]}, {24'd0, expected});
         end
         if (outCount[d] == 0) firstOut[d] = cycle;
         lastOut[d] = cycle;
         outCount[d]++;
      end
   endtask

   // Outputs are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         watchOutput(0);
         watchOutput(1);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offers one beat on each stream of DUT d and waits (bounded) until both
   // are accepted; the joined value is queued as soon as it is driven.
   task automatic applyStimulus(input int d, input logic [3:0] a, input logic [3:0] b);
      bit got0 = 1'b0;
      bit got1 = 1'b0;
      int waitCycles = 0;
      pushExpected(d, {a, b});
      data0[d]  = a;
      data1[d]  = b;
      valid0[d] = 1'b1;
      valid1[d] = 1'b1;
      while (!(got0 && got1) && waitCycles < 64) begin
         @(negedge clk);
         if (valid0[d] && ready0[d]) got0 = 1'b1;
         if (valid1[d] && ready1[d]) got1 = 1'b1;
         @(posedge clk);
         #1;
         if (got0) valid0[d] = 1'b0;
         if (got1) valid1[d] = 1'b0;
         waitCycles++;
      end
      if (!(got0 && got1)) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
         valid0[d] = 1'b0;
         valid1[d] = 1'b0;
      end
   endtask

   // Hard stop in case a scenario wedges the simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios: reset, simultaneous and skewed arrival,
   // backpressure, throughput for both BURST settings, mid-run reset.
   initial begin
      valid0   = '0;
      valid1   = '0;
      data0    = '0;
      data1    = '0;
      outReady = 2'b11;
      for (int d = 0; d < 2; d++) begin
         outCount[d] = 0;
         firstOut[d] = 0;
         lastOut[d]  = 0;
      end

      // Reset state for both builds.
      #12;
      for (int d = 0; d < 2; d++) begin
         checkOutput("rstValid",  {31'd0, outValid[d]}, 32'd0);
         checkOutput("rstData",   {24'd0, outData[d]},  32'h00);
         checkOutput("rstReady0", {31'd0, ready0[d]},   32'd1);
         checkOutput("rstReady1", {31'd0, ready1[d]},   32'd1);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(1);

      // Simultaneous arrival: output valid exactly two edges after accept.
      for (int d = 0; d < 2; d++) begin
         pushExpected(d, 8'hab);
         data0[d]  = 4'ha;
         data1[d]  = 4'hb;
         valid0[d] = 1'b1;
         valid1[d] = 1'b1;
         tick(1);
         valid0[d] = 1'b0;
         valid1[d] = 1'b0;
         checkOutput("simEarly", {31'd0, outValid[d]}, 32'd0);
         tick(1);
         checkOutput("simValid", {31'd0, outValid[d]}, 32'd1);
         checkOutput("simData",  {24'd0, outData[d]},  32'hab);
         tick(1);
         checkOutput("simOneCycle", {31'd0, outValid[d]}, 32'd0);
         tick(1);
      end

      // Skewed arrival on the burst build: stream 1 three cycles late.
      data0[0]  = 4'h7;
      valid0[0] = 1'b1;
      tick(1);
      valid0[0] = 1'b0;
      pushExpected(0, 8'h78);
      checkOutput("skewReady0", {31'd0, ready0[0]}, 32'd0);
      tick(1);
      checkOutput("skewReady0Hold", {31'd0, ready0[0]}, 32'd0);
      tick(1);
      checkOutput("skewNoOut", {31'd0, outValid[0]}, 32'd0);
      data1[0]  = 4'h8;
      valid1[0] = 1'b1;
      tick(1);
      valid1[0] = 1'b0;
      checkOutput("skewNotYet", {31'd0, outValid[0]}, 32'd0);
      tick(1);
      checkOutput("skewValid", {31'd0, outValid[0]}, 32'd1);
      checkOutput("skewData",  {24'd0, outData[0]},  32'h78);
      tick(2);

      // Backpressure: two pairs pile up, the first is held stable.
      outReady[0] = 1'b0;
      pushExpected(0, 8'h34);
      data0[0]  = 4'h3;
      data1[0]  = 4'h4;
      valid0[0] = 1'b1;
      valid1[0] = 1'b1;
      tick(1);
      pushExpected(0, 8'h56);
      data0[0] = 4'h5;
      data1[0] = 4'h6;
      tick(1);
      valid0[0] = 1'b0;
      valid1[0] = 1'b0;
      checkOutput("bpValid",  {31'd0, outValid[0]}, 32'd1);
      checkOutput("bpData",   {24'd0, outData[0]},  32'h34);
      checkOutput("bpReady0", {31'd0, ready0[0]},   32'd0);
      checkOutput("bpReady1", {31'd0, ready1[0]},   32'd0);
      tick(3);
      checkOutput("bpStable",     {24'd0, outData[0]}, 32'h34);
      checkOutput("bpReady0Hold", {31'd0, ready0[0]},  32'd0);
      outReady[0] = 1'b1;
      tick(4);
      checkOutput("bpDrained", expQ0.size(), 32'd0);

      // Throughput: 8 back-to-back pairs on each build.
      for (int d = 0; d < 2; d++) begin
         outCount[d] = 0;
         for (int i = 0; i < 8; i++) begin
            applyStimulus(d, 4'(i), 4'(15 - i));
         end
         tick(8);
         checkOutput(d == 0 ? "tpCountYes" : "tpCountNo", outCount[d], 32'd8);
         checkOutput(d == 0 ? "tpSpanYes" : "tpSpanNo",
                     lastOut[d] - firstOut[d], d == 0 ? 32'd7 : 32'd14);
      end

      // Mid-run reset with slot 0 full and the output valid.
      outReady[0] = 1'b0;
      pushExpected(0, 8'h12);
      data0[0]  = 4'h1;
      data1[0]  = 4'h2;
      valid0[0] = 1'b1;
      valid1[0] = 1'b1;
      tick(1);
      valid0[0] = 1'b0;
      valid1[0] = 1'b0;
      tick(1);
      data0[0]  = 4'h9;
      valid0[0] = 1'b1;
      tick(1);
      valid0[0] = 1'b0;
      checkOutput("preRstValid", {31'd0, outValid[0]}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midRstValid",  {31'd0, outValid[0]}, 32'd0);
      checkOutput("midRstData",   {24'd0, outData[0]},  32'h00);
      checkOutput("midRstReady0", {31'd0, ready0[0]},   32'd1);
      checkOutput("midRstReady1", {31'd0, ready1[0]},   32'd1);
      expQ0.delete();
      tick(1);
      reset       = 1'b0;
      outReady[0] = 1'b1;
      tick(5);
      applyStimulus(0, 4'hc, 4'hd);
      tick(4);
      checkOutput("finalQueueYes", expQ0.size(), 32'd0);
      checkOutput("finalQueueNo",  expQ1.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
